// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction/memory handshake and datapath control bundle between controller and datapath
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0] ir;
  logic mem_ready;
  logic pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic halted, illegal;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  modport master(
    input ir, mem_ready,
    output pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
    output halted, illegal, state, retired
  );
  modport slave(
    output ir, mem_ready,
    input pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write, ir_write,
    input mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
    input halted, illegal, state, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory stall, halt detection and retire counter
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB, HALT
  } state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] retired;
  logic halted, bad, done;
  logic [5:0] op;
  assign op = bus.ir[31:26];
  always_comb begin
    nxt = FETCH;
    bad = 1'b0;
    case (st)
      FETCH: nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        if (bus.ir == HALT_WORD) nxt = HALT;
        else if (op == 6'h00) nxt = EXEC;
        else if (op == 6'h23 || op == 6'h2b) nxt = MEMADR;
        else if (op == 6'h04 || op == 6'h05) nxt = BRANCH;
        else if (op == 6'h02) nxt = JUMP;
        else if (op == 6'h08) nxt = ADDIEX;
        else bad = 1'b1;
      MEMADR: nxt = op == 6'h23 ? MEMRD : MEMWR;
      MEMRD: nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: nxt = bus.mem_ready ? FETCH : MEMWR;
      EXEC: nxt = RWB;
      ADDIEX: nxt = ADDIWB;
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
  end
  // an instruction retires on the edge that leaves its final state
  assign done = st == MEMWB || (st == MEMWR && bus.mem_ready) || st == RWB ||
                st == BRANCH || st == JUMP || st == ADDIWB;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= FETCH;
      retired <= '0;
      halted <= 1'b0;
    end else begin
      st <= nxt;
      retired <= retired + CNT_W'(done);
      halted <= halted | (nxt == HALT);
    end
  end
  assign bus.mem_read = rst_n && (st == FETCH || st == MEMRD);
  assign bus.mem_write = rst_n && st == MEMWR;
  assign bus.ir_write = rst_n && st == FETCH && bus.mem_ready;
  assign bus.pc_write = rst_n && ((st == FETCH && bus.mem_ready) || st == JUMP);
  assign bus.pc_write_eq = rst_n && st == BRANCH && op == 6'h04;
  assign bus.pc_write_ne = rst_n && st == BRANCH && op == 6'h05;
  assign bus.reg_write = rst_n && (st == MEMWB || st == RWB || st == ADDIWB);
  assign bus.illegal = rst_n && bad;
  assign bus.i_or_d = st == MEMRD || st == MEMWR;
  assign bus.mem_to_reg = st == MEMWB;
  assign bus.reg_dst = st == RWB;
  assign bus.alu_src_a = st == MEMADR || st == EXEC || st == BRANCH || st == ADDIEX;
  assign bus.alu_src_b = st == FETCH ? 2'b01 : st == DECODE ? 2'b11 :
                         (st == MEMADR || st == ADDIEX) ? 2'b10 : 2'b00;
  assign bus.alu_op = st == EXEC ? 2'b10 : st == BRANCH ? 2'b01 : 2'b00;
  assign bus.pc_source = st == BRANCH ? 2'b01 : st == JUMP ? 2'b10 : 2'b00;
  assign bus.halted = halted;
  assign bus.state = st;
  assign bus.retired = retired;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized scoreboard bench for the multi-cycle MIPS controller
module tb_mips_multicycle_ctrl;
  logic clk, rst_n;
  mips_multicycle_ctrl_if #(.CNT_W(32)) bus();
  mips_multicycle_ctrl #(.CNT_W(32), .HALT_WORD(32'hFFFFFFFF)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [3:0] st;
    logic [17:0] o;
    logic [31:0] ret;
    logic hlt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] m_ret = 0;
  logic m_hlt = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  // expected control word for a cycle, taken from the per-step control table
  function automatic logic [17:0] outs(input logic [3:0] s, input logic [5:0] op, input logic rdy,
                                        input logic rn, input logic ill);
    logic pw, pe, pn, iod, mr, mw, irw, m2r, rd, rw, sa, il;
    logic [1:0] sb, ao, ps;
    {pw, pe, pn, iod, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
    {sb, ao, ps} = '0;
    case (s)
      4'd0: begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
      4'd1: begin sb = 2'b11; il = ill; end
      4'd2: begin sa = 1; sb = 2'b10; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iod = 1; end
      4'd6: begin sa = 1; ao = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin sa = 1; ao = 2'b01; ps = 2'b01; pe = op == 6'h04; pn = op == 6'h05; end
      4'd9: begin ps = 2'b10; pw = 1; end
      4'd10: begin sa = 1; sb = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    if (!rn) {pw, pe, pn, mr, mw, irw, rw, il} = '0;
    return {pw, pe, pn, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, il};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state", 32'(bus.state), 32'(e.st));
      chk("outs", 32'({bus.pc_write, bus.pc_write_eq, bus.pc_write_ne, bus.i_or_d, bus.mem_read,
                       bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                       bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal}), 32'(e.o));
      chk("retired", bus.retired, e.ret);
      chk("halted", 32'(bus.halted), 32'(e.hlt));
    end
  end
  task automatic step(input logic [31:0] w, input logic [3:0] s, input logic rdy, input logic rn,
                      input logic ill, input logic inc, input logic seth);
    exp_t e;
    @(posedge clk);
    #1;
    bus.ir = w;
    bus.mem_ready = rdy;
    rst_n = rn;
    e.st = s;
    e.o = outs(s, w[31:26], rdy, rn, ill);
    e.ret = m_ret;
    e.hlt = m_hlt;
    q.push_back(e);
    if (!rn) begin
      m_ret = 0;
      m_hlt = 0;
    end else begin
      m_ret = m_ret + 32'(inc);
      if (seth) m_hlt = 1;
    end
  endtask
  task automatic instr(input logic [31:0] w, input int wf, input int wm, input int nh);
    logic [5:0] op;
    logic [3:0] ms;
    op = w[31:26];
    ms = op == 6'h23 ? 4'd3 : 4'd5;
    repeat (wf) step(w, 0, 0, 1, 0, 0, 0);
    step(w, 0, 1, 1, 0, 0, 0);
    if (w == 32'hFFFFFFFF) begin
      step(w, 1, rb(), 1, 0, 0, 1);
      repeat (nh) step(w, 12, rb(), 1, 0, 0, 0);
    end else if (op == 6'h00) begin
      step(w, 1, rb(), 1, 0, 0, 0);
      step(w, 6, rb(), 1, 0, 0, 0);
      step(w, 7, rb(), 1, 0, 1, 0);
    end else if (op == 6'h23 || op == 6'h2b) begin
      step(w, 1, rb(), 1, 0, 0, 0);
      step(w, 2, rb(), 1, 0, 0, 0);
      repeat (wm) step(w, ms, 0, 1, 0, 0, 0);
      if (op == 6'h23) begin
        step(w, 3, 1, 1, 0, 0, 0);
        step(w, 4, rb(), 1, 0, 1, 0);
      end else step(w, 5, 1, 1, 0, 1, 0);
    end else if (op == 6'h04 || op == 6'h05) begin
      step(w, 1, rb(), 1, 0, 0, 0);
      step(w, 8, rb(), 1, 0, 1, 0);
    end else if (op == 6'h02) begin
      step(w, 1, rb(), 1, 0, 0, 0);
      step(w, 9, rb(), 1, 0, 1, 0);
    end else if (op == 6'h08) begin
      step(w, 1, rb(), 1, 0, 0, 0);
      step(w, 10, rb(), 1, 0, 0, 0);
      step(w, 11, rb(), 1, 0, 1, 0);
    end else step(w, 1, rb(), 1, 1, 0, 0);
  endtask
  function automatic logic [31:0] rand_instr();
    logic [25:0] lo;
    logic [5:0] op;
    lo = 26'($urandom);
    case ($urandom_range(0, 7))
      0: op = 6'h00;
      1: op = 6'h23;
      2: op = 6'h2b;
      3: op = 6'h04;
      4: op = 6'h05;
      5: op = 6'h02;
      6: op = 6'h08;
      default: begin
        op = 6'($urandom);
        while (op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08}) op = 6'($urandom);
        lo[0] = 1'b0;
      end
    endcase
    return {op, lo};
  endfunction
  initial begin
    rst_n = 0;
    bus.ir = '0;
    bus.mem_ready = 0;
    @(posedge clk);
    step(32'h0, 0, 0, 0, 0, 0, 0);
    instr(32'h012A4020, 0, 0, 0);
    instr(32'h8D090004, 3, 2, 0);
    instr(32'h11090002, 0, 0, 0);
    instr(32'h15090002, 0, 0, 0);
    instr(32'hFC000000, 0, 0, 0);
    instr(32'h21290005, 1, 0, 0);
    instr(32'h08000010, 0, 0, 0);
    for (int i = 0; i < 150; i++) instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 0);
    step(32'hAD090008, 0, 1, 1, 0, 0, 0);
    step(32'hAD090008, 1, rb(), 1, 0, 0, 0);
    step(32'hAD090008, 2, rb(), 1, 0, 0, 0);
    step(32'hAD090008, 5, 0, 1, 0, 0, 0);
    step(32'hAD090008, 5, 0, 0, 0, 0, 0);
    instr(32'h012A4020, 0, 0, 0);
    instr(32'hAD090008, 0, 0, 0);
    instr(32'hFFFFFFFF, 0, 0, 10);
    step(32'hFFFFFFFF, 12, rb(), 0, 0, 0, 0);
    instr(32'h012A4020, 2, 0, 0);
    for (int i = 0; i < 20; i++) instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2), 0);
    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
